// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - UART receive frame controller
//
// Detects the start edge on RX_IN, runs the oversample edge counter and the
// data bit counter, deserializes LSB-first data from the voted sampled_bit,
// checks optional parity and the stop bit, and presents good frames on P_DATA
// with a one-cycle data_valid pulse.
//
// Ports:
//   CLK                 oversampling clock (prescale x baud)
//   RST                 asynchronous active-low reset
//   RX_IN               synchronized serial line, idle high
//   prescale            oversampling ratio (8, 16 or 32), stable outside IDLE
//   PAR_EN              frame carries a parity bit, latched on leaving IDLE
//   PAR_TYP             0 even / 1 odd parity, latched on leaving IDLE
//   sampled_bit         majority-voted bit from the data sampler
//   data_sample_enable  high whenever a frame is in progress
//   edge_cnt            oversample index within the current bit
//   P_DATA              data of the last good frame
//   data_valid          one-cycle pulse per good frame
//   par_err             parity mismatch on the current/last frame
//   stp_err             stop bit sampled low on the current/last frame

module uart_rx_controller #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  sampled_bit,
   output logic                  data_sample_enable,
   output logic [5:0]            edge_cnt,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BCW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q;
   logic [5:0]            edge_cnt_q;
   logic [5:0]            edge_cnt_d;
   logic [BCW-1:0]        bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic                  data_valid_q;
   logic                  par_err_q;
   logic                  stp_err_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  bit_end;
   logic                  last_data_bit;
   logic                  par_expected;

   // The last oversample of a bit is the only point where decisions are made.
   assign bit_end       = (edge_cnt_q == (prescale - 6'd1));
   assign edge_cnt_d    = bit_end ? 6'd0 : (edge_cnt_q + 6'd1);
   assign last_data_bit = (bit_cnt_q == BCW'(DATA_WIDTH - 1));
   // Even parity expects the XOR of the data; odd parity expects its inverse.
   assign par_expected  = (^shift_q) ^ par_typ_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         edge_cnt_q   <= 6'd0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         if (state_q == IDLE) begin
            edge_cnt_q <= 6'd0;
            if (!RX_IN) begin
               state_q   <= START;
               par_en_q  <= PAR_EN;
               par_typ_q <= PAR_TYP;
               par_err_q <= 1'b0;
               stp_err_q <= 1'b0;
            end
         end else begin
            edge_cnt_q <= edge_cnt_d;
            if (bit_end) begin
               case (state_q)
                  START: begin
                     // A start bit that votes high was a glitch, not a frame.
                     if (!sampled_bit) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
                  DATA: begin
                     // Shifting in at the MSB leaves bit 0 in the LSB at the end.
                     shift_q   <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                     if (last_data_bit) begin
                        state_q <= par_en_q ? PARITY : STOP;
                     end
                  end
                  PARITY: begin
                     par_err_q <= (sampled_bit != par_expected);
                     state_q   <= STOP;
                  end
                  STOP: begin
                     stp_err_q <= ~sampled_bit;
                     state_q   <= IDLE;
                     if (!par_err_q && sampled_bit) begin
                        p_data_q     <= shift_q;
                        data_valid_q <= 1'b1;
                     end
                  end
                  default: state_q <= IDLE;
               endcase
            end
         end
      end
   end

   assign data_sample_enable = (state_q != IDLE);
   assign edge_cnt           = edge_cnt_q;
   assign P_DATA             = p_data_q;
   assign data_valid         = data_valid_q;
   assign par_err            = par_err_q;
   assign stp_err            = stp_err_q;

endmodule
